// File: rtl/q_update.sv
// One Q-learning update per request: read Q(s,a), blend in r + gamma*maxQ',
// write the saturated result back. Illegal actions complete at once with err and no write.
module q_update #(
  parameter int ADDR_W      = 8,
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_SHIFT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] state_idx,
  input  logic [3:0]        action,
  input  logic [15:0]       reward,
  input  logic [15:0]       max_next_q,
  output logic              q_rd_en,
  output logic [ADDR_W+3:0] q_rd_addr,
  input  logic [15:0]       q_rd_data,
  output logic              q_wr_en,
  output logic [ADDR_W+3:0] q_wr_addr,
  output logic [15:0]       q_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] CALC  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W+3:0] r_addr;
  logic [15:0]       r_reward;
  logic [15:0]       r_maxq;
  logic [15:0]       r_q;
  logic [15:0]       r_qnew;
  logic              r_err;

  logic signed [18:0] w_g;
  logic signed [18:0] w_target;
  logic signed [18:0] w_delta;
  logic signed [18:0] w_step;
  logic signed [18:0] w_sum;
  logic [15:0]        w_qsat;

  // gamma*maxQ' as maxQ' minus its own fraction; all terms kept 19-bit signed
  assign w_g      = $signed({3'b000, r_maxq}) - $signed({3'b000, r_maxq >> GAMMA_SHIFT});
  assign w_target = $signed({{3{r_reward[15]}}, r_reward}) + w_g;
  assign w_delta  = w_target - $signed({3'b000, r_q});
  assign w_step   = w_delta >>> ALPHA_SHIFT;
  assign w_sum    = $signed({3'b000, r_q}) + w_step;
  assign w_qsat   = w_sum[18] ? 16'd0 : ((|w_sum[17:16]) ? 16'hFFFF : w_sum[15:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_reward <= '0;
      r_maxq   <= '0;
      r_q      <= '0;
      r_qnew   <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_addr   <= {state_idx, action};
            r_reward <= reward;
            r_maxq   <= max_next_q;
            if (action > 4'd8) begin
              r_err   <= 1'b1;
              r_state <= WRITE;
            end else begin
              r_err   <= 1'b0;
              r_state <= READ;
            end
          end
        end
        READ:  r_state <= WAIT;
        WAIT: begin
          r_q     <= q_rd_data;
          r_state <= CALC;
        end
        CALC: begin
          r_qnew  <= w_qsat;
          r_state <= WRITE;
        end
        WRITE:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state; addresses and data are zeroed off-strobe
  assign q_rd_en   = (r_state == READ);
  assign q_rd_addr = q_rd_en ? r_addr : '0;
  assign q_wr_en   = (r_state == WRITE) && !r_err;
  assign q_wr_addr = q_wr_en ? r_addr : '0;
  assign q_wr_data = q_wr_en ? r_qnew : '0;
  assign done      = (r_state == WRITE);
  assign err       = done && r_err;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_q_update.sv
// Directed bench for q_update: a one-word table model answers reads one cycle late,
// each scenario task checks strobes, addresses and data cycle by cycle.
module tb_q_update;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  state_idx;
  logic [3:0]  action;
  logic [15:0] reward;
  logic [15:0] max_next_q;
  logic        q_rd_en;
  logic [11:0] q_rd_addr;
  logic [15:0] q_rd_data;
  logic        q_wr_en;
  logic [11:0] q_wr_addr;
  logic [15:0] q_wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  int total;
  int bad;
  int rd_count;
  int wr_count;
  logic [15:0] ram_q;

  q_update #(.ADDR_W(8), .ALPHA_SHIFT(2), .GAMMA_SHIFT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .state_idx(state_idx), .action(action),
    .reward(reward), .max_next_q(max_next_q), .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr),
    .q_rd_data(q_rd_data), .q_wr_en(q_wr_en), .q_wr_addr(q_wr_addr), .q_wr_data(q_wr_data),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // table model: data valid the cycle after the read strobe, junk otherwise
  always @(posedge clk) begin
    q_rd_data <= q_rd_en ? ram_q : 16'hDEAD;
  end

  always @(negedge clk) begin
    if (q_rd_en) rd_count++;
    if (q_wr_en) wr_count++;
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({q_rd_en, q_wr_en, busy, done, err} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=00000", {q_rd_en, q_wr_en, busy, done, err});
    end
    total++; if ({q_rd_addr, q_wr_addr, q_wr_data} !== 40'd0) begin
      bad++; $display("FAIL reset_buses got=%h exp=0", {q_rd_addr, q_wr_addr, q_wr_data});
    end
    total++; if (dbg_state !== 3'd0) begin
      bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Caller sits at a negedge of an idle cycle; returns at the negedge of the idle cycle after done.
  task automatic do_update(input string name, input logic [7:0] s, input logic [3:0] a,
                           input logic [15:0] q, input logic [15:0] r, input logic [15:0] m,
                           input logic [15:0] exp_data);
    logic [11:0] exp_addr;
    int wr0;
    exp_addr = {s, a};
    wr0 = wr_count;
    ram_q = q; state_idx = s; action = a; reward = r; max_next_q = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (q_rd_en !== 1'b1 || q_rd_addr !== exp_addr || busy !== 1'b1) begin
      bad++; $display("FAIL %s_read got=en%b addr%h busy%b exp=en1 addr%h busy1", name, q_rd_en, q_rd_addr, busy, exp_addr);
    end
    @(negedge clk);
    total++; if (q_rd_en !== 1'b0 || q_rd_addr !== 12'd0 || q_wr_en !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL %s_wait got=rd%b addr%h wr%b done%b exp=0 0 0 0", name, q_rd_en, q_rd_addr, q_wr_en, done);
    end
    @(negedge clk);
    @(negedge clk);
    total++; if (q_wr_en !== 1'b1 || q_wr_addr !== exp_addr || done !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL %s_write got=wr%b addr%h done%b err%b exp=wr1 addr%h done1 err0", name, q_wr_en, q_wr_addr, done, err, exp_addr);
    end
    total++; if (q_wr_data !== exp_data) begin
      bad++; $display("FAIL %s_data got=%0d exp=%0d", name, q_wr_data, exp_data);
    end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || q_wr_en !== 1'b0 || wr_count != wr0 + 1) begin
      bad++; $display("FAIL %s_end got=busy%b done%b wr%b writes%0d exp=0 0 0 writes%0d", name, busy, done, q_wr_en, wr_count - wr0, 1);
    end
  endtask

  task automatic test_basic();
    do_update("basic", 8'd5, 4'd4, 16'd1000, 16'd100, 16'd2000, 16'd1212);
  endtask

  task automatic test_negative();
    do_update("negative", 8'd17, 4'd0, 16'd1000, -16'sd500, 16'd0, 16'd625);
  endtask

  task automatic test_saturation();
    do_update("sat_low", 8'd200, 4'd8, 16'd10, 16'h8000, 16'd0, 16'd0);
    do_update("sat_high", 8'd255, 4'd1, 16'd65000, 16'd32767, 16'd65535, 16'd65535);
  endtask

  task automatic test_illegal_action();
    int rd0;
    int wr0;
    rd0 = rd_count; wr0 = wr_count;
    state_idx = 8'd5; action = 4'd9; reward = 16'd100; max_next_q = 16'd2000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL illegal_done got=done%b err%b busy%b exp=1 1 1", done, err, busy);
    end
    total++; if (q_wr_en !== 1'b0 || q_rd_en !== 1'b0 || q_wr_addr !== 12'd0 || q_wr_data !== 16'd0) begin
      bad++; $display("FAIL illegal_strobes got=rd%b wr%b addr%h data%h exp=0", q_rd_en, q_wr_en, q_wr_addr, q_wr_data);
    end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL illegal_after got=busy%b done%b err%b exp=0 0 0", busy, done, err);
    end
    repeat (3) @(negedge clk);
    total++; if (rd_count != rd0 || wr_count != wr0) begin
      bad++; $display("FAIL illegal_no_access got=rd%0d wr%0d exp=0 0", rd_count - rd0, wr_count - wr0);
    end
  endtask

  task automatic test_protocol();
    int wr0;
    wr0 = wr_count;
    ram_q = 16'd1000; state_idx = 8'd3; action = 4'd2; reward = 16'd100; max_next_q = 16'd2000;
    start = 1'b1;
    @(negedge clk);
    // cycle 1: scramble operands; stray starts in cycles 2 and 3
    start = 1'b0; state_idx = 8'd7; action = 4'd1; reward = 16'd9999; max_next_q = 16'd1;
    @(negedge clk);
    start = 1'b1; action = 4'd12;
    @(negedge clk);
    start = 1'b1; action = 4'd3;
    @(negedge clk);
    start = 1'b0;
    total++; if (q_wr_en !== 1'b1 || q_wr_addr !== 12'h032 || q_wr_data !== 16'd1212 || err !== 1'b0) begin
      bad++; $display("FAIL protocol_write got=wr%b addr%h data%0d err%b exp=wr1 addr032 data1212 err0", q_wr_en, q_wr_addr, q_wr_data, err);
    end
    repeat (4) @(negedge clk);
    total++; if (wr_count != wr0 + 1 || busy !== 1'b0) begin
      bad++; $display("FAIL protocol_single got=writes%0d busy%b exp=writes1 busy0", wr_count - wr0, busy);
    end
  endtask

  task automatic test_back_to_back();
    do_update("b2b_first", 8'd1, 4'd5, 16'd400, 16'd0, 16'd800, 16'd475);
    do_update("b2b_second", 8'd2, 4'd6, 16'd0, 16'd8, 16'd0, 16'd2);
  endtask

  task automatic test_reset_mid();
    int wr0;
    wr0 = wr_count;
    ram_q = 16'd1000; state_idx = 8'd9; action = 4'd3; reward = 16'd100; max_next_q = 16'd2000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (dbg_state !== 3'd3) begin
      bad++; $display("FAIL rstmid_in_calc got=%0d exp=3", dbg_state);
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({q_rd_en, q_wr_en, busy, done, err} !== 5'b0 || {q_rd_addr, q_wr_addr, q_wr_data} !== 40'd0) begin
      bad++; $display("FAIL rstmid_outputs got=%b %h exp=0", {q_rd_en, q_wr_en, busy, done, err}, {q_rd_addr, q_wr_addr, q_wr_data});
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (wr_count != wr0 || busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_no_write got=writes%0d busy%b exp=0 0", wr_count - wr0, busy);
    end
  endtask

  initial begin
    total = 0; bad = 0; rd_count = 0; wr_count = 0;
    rst = 1'b1; start = 1'b0; state_idx = '0; action = '0; reward = '0; max_next_q = '0;
    ram_q = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_illegal_action();
    test_protocol();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/q_update.md
Name: q_update

Overview:
- Write-side companion to the max-Q selector. Performs one Q-learning update on the external Q-table per request:
  Q(s,a) <- Q(s,a) + alpha*(r + gamma*maxQ' - Q(s,a))
- maxQ' is the next-state maximum produced by the max-Q selector. alpha and gamma are power-of-two shifts.
- Sits between the learning controller and the Q-table RAM. It owns one read and one write transaction per update.

Parameters:
- ADDR_W, 8: state index width. Table address is {state_idx, action[3:0]}, width ADDR_W+4.
- ALPHA_SHIFT, 2: alpha = 2^-ALPHA_SHIFT. Legal range 0..8.
- GAMMA_SHIFT, 3: gamma = 1 - 2^-GAMMA_SHIFT. Legal range 1..8.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request strobe; sampled only in IDLE.
- state_idx  in  ADDR_W  current state s.
- action  in  4  action a; cell 0..8.
- reward  in  16  signed reward r (two's complement).
- max_next_q  in  16  unsigned maxQ' from the max-Q selector.
- q_rd_en  out  1  table read strobe.
- q_rd_addr  out  ADDR_W+4  read address.
- q_rd_data  in  16  unsigned Q; valid exactly one cycle after q_rd_en.
- q_wr_en  out  1  table write strobe.
- q_wr_addr  out  ADDR_W+4  write address.
- q_wr_data  out  16  unsigned updated Q.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = action out of range, no write performed.

Behaviour:
- Reset: all outputs 0; FSM enters IDLE; latched operands cleared. Reset during any state aborts the update. No q_wr_en is issued after the reset cycle.
- On start in IDLE:
  - Latch state_idx, action, reward and max_next_q.
  - Later changes on these inputs are ignored until the update finishes.
- start is ignored whenever busy=1. It is not queued.
- FSM states: IDLE, READ, WAIT, CALC, WRITE. Transitions and per-state outputs, with start sampled at edge 0:
  - IDLE -> READ on start with action<=8. IDLE -> WRITE with err path on start with action>8.
  - READ (cycle 1): q_rd_en=1, q_rd_addr={s,a}. Next state WAIT.
  - WAIT (cycle 2): capture q_rd_data as Q. Next state CALC.
  - CALC (cycle 3): compute and register q_new. Next state WRITE.
  - WRITE (cycle 4): q_wr_en=1, q_wr_addr={s,a}, q_wr_data=q_new, done=1, err=0. Next state IDLE.
  - Error path, WRITE in cycle 1: q_wr_en=0, done=1, err=1. No read is issued.
- Latency: done 4 cycles after start, 1 cycle on the error path. New start is accepted in the cycle after done (throughput 1 update per 5 cycles).
- q_rd_addr, q_wr_addr and q_wr_data read 0 whenever their strobe is low.
- Arithmetic: all intermediates are 19-bit signed.
  - g = maxQ' - (maxQ' >> GAMMA_SHIFT), logical shift.
  - target = sign_extend(r) + g.
  - delta = target - Q.
  - step = delta >>> ALPHA_SHIFT, arithmetic shift, rounds toward -inf.
  - q_new = Q + step, saturated to 0..65535.
- Read and write of the same address never overlap, because the write occurs 3 cycles after the read.

Test Plan:
- Basic update, ALPHA_SHIFT=2, GAMMA_SHIFT=3. Inputs s=5, a=4, Q=1000, r=100, maxQ'=2000.
  - Required: q_rd_en at cycle 1 with addr 0x054.
  - Required: write at cycle 4 with addr 0x054, data 1212; done=1, err=0 in the same cycle.
- Negative reward: Q=1000, r=-500, maxQ'=0 -> q_wr_data=625.
- Saturation:
  - Q=10, r=-32768, maxQ'=0 -> step=-8195, q_wr_data=0.
  - Q=65000, r=32767, maxQ'=65535 -> q_wr_data=65535.
- Illegal action: start with a=9 -> done=1, err=1 at cycle 1; no q_rd_en or q_wr_en ever asserted; busy drops in the next cycle.
- Protocol:
  - start pulsed at cycles 2 and 3 during an update: both ignored, exactly one write, inputs changed after start have no effect.
  - Back-to-back: start in the cycle after done is accepted.
- Reset mid-operation: rst asserted in CALC -> next cycle all outputs 0 and busy=0; no write ever occurs for that request.
